// File: rtl/ped_crossing_panel.sv
// ped_crossing_panel
// Pedestrian-side companion to the traffic light controller. It debounces the
// raw crossing button, requests a shortened green from the controller, and
// drives the WALK / DON'T WALK lamps plus a two-digit BCD countdown taken from
// the controller's clock. Pedestrians cross while the vehicle light is red.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   button        in   raw bouncy push button, active-high, asynchronous
//   red/yellow/green in vehicle lights from the controller (clk domain)
//   clock[7:0]    in   controller countdown, unsigned
//   pass_request  out  ask controller to shorten green
//   walk          out  WALK lamp
//   dont_walk     out  DON'T WALK lamp (flashes during clearance)
//   req_pending   out  "request registered" indicator
//   fault         out  more than one vehicle light high this cycle
//   cnt_tens/ones out  BCD countdown digits
//   cnt_blank     out  display blank
//
// State  | meaning
// IDLE   | no request, DON'T WALK solid
// WAIT   | request registered, waiting for red to start
// WALK   | pedestrians may cross
// CLEAR  | crossing closing, DON'T WALK flashing
module ped_crossing_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_WALK        = 5,
  parameter int CLEAR_TIME      = 3,
  parameter int FLASH_HALF      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic [7:0] clock,
  output logic       pass_request,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic       fault,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       cnt_blank
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WALK, S_CLEAR} state_t;

  state_t        state, state_nx;
  logic          sync1, sync2;
  logic          btn_state;
  logic [DW-1:0] deb_cnt;
  logic          press;
  logic          red_prev;
  logic          pend, pend_nx;
  logic [FW-1:0] flash_cnt, flash_cnt_nx;
  logic          flash_lvl, flash_lvl_nx;

  logic          fault_c;
  logic          red_rise;
  logic          show;
  logic [6:0]    clamp;
  logic [3:0]    tens_c, ones_c;

  // Button synchronizer and debounce. press is a registered one-cycle pulse
  // on an accepted 0->1 change, so the FSM sees it one edge after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_state <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == btn_state) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_state <= sync2;
        deb_cnt   <= '0;
        press     <= sync2;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // All-dark is legal; only two or more simultaneous lights is a fault.
  assign fault_c  = (red & yellow) | (red & green) | (yellow & green);
  assign red_rise = red & ~red_prev;

  always_comb begin
    state_nx     = state;
    pend_nx      = pend;
    flash_cnt_nx = flash_cnt;
    flash_lvl_nx = flash_lvl;
    if (fault_c) begin
      state_nx = S_IDLE;
      pend_nx  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (press) begin
            if (red && (clock > 8'(MIN_WALK))) state_nx = S_WALK;
            else                               state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (red_rise) state_nx = S_WALK;
        end
        S_WALK: begin
          if (!red)                            state_nx = S_IDLE;
          else if (clock <= 8'(CLEAR_TIME))    state_nx = S_CLEAR;
        end
        S_CLEAR: begin
          // A press in the same cycle red falls still counts.
          if (!red) begin
            state_nx = (pend || press) ? S_WAIT : S_IDLE;
            pend_nx  = 1'b0;
          end else if (press) begin
            pend_nx = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end

    // Flash phase restarts lit on every entry into CLEAR.
    if (state_nx == S_CLEAR) begin
      if (state != S_CLEAR) begin
        flash_cnt_nx = '0;
        flash_lvl_nx = 1'b1;
      end else if (flash_cnt == FW'(FLASH_HALF - 1)) begin
        flash_cnt_nx = '0;
        flash_lvl_nx = ~flash_lvl;
      end else begin
        flash_cnt_nx = flash_cnt + FW'(1);
      end
    end
  end

  assign show  = (state_nx == S_WALK) || (state_nx == S_CLEAR);
  assign clamp = (clock > 8'd99) ? 7'd99 : clock[6:0];

  always_comb begin
    tens_c = 4'(clamp / 7'd10);
    ones_c = 4'(clamp % 7'd10);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      red_prev     <= 1'b0;
      pend         <= 1'b0;
      flash_cnt    <= '0;
      flash_lvl    <= 1'b0;
      pass_request <= 1'b0;
      walk         <= 1'b0;
      dont_walk    <= 1'b1;
      req_pending  <= 1'b0;
      fault        <= 1'b0;
      cnt_tens     <= 4'd0;
      cnt_ones     <= 4'd0;
      cnt_blank    <= 1'b1;
    end else begin
      state        <= state_nx;
      red_prev     <= red;
      pend         <= pend_nx;
      flash_cnt    <= flash_cnt_nx;
      flash_lvl    <= flash_lvl_nx;
      // Never request during red/yellow: the controller would read it as
      // "end red now".
      pass_request <= (state_nx == S_WAIT) && green;
      req_pending  <= (state_nx == S_WAIT);
      walk         <= (state_nx == S_WALK);
      fault        <= fault_c;
      if (state_nx == S_WALK)       dont_walk <= 1'b0;
      else if (state_nx == S_CLEAR) dont_walk <= flash_lvl_nx;
      else                          dont_walk <= 1'b1;
      cnt_blank <= ~show;
      cnt_tens  <= show ? tens_c : 4'd0;
      cnt_ones  <= show ? ones_c : 4'd0;
    end
  end

endmodule

// File: tb/tb_ped_crossing_panel.sv
// Bench for ped_crossing_panel: a cycle model built from the behavioural rules
// (sample windows, crossing phases, time-in-clearance) is compared against
// every output after each edge, and directed scenarios add literal checks.
module tb_ped_crossing_panel;

  localparam int D  = 4;
  localparam int MW = 5;
  localparam int CT = 3;
  localparam int FH = 2;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_CROSS = 2;
  localparam int P_CLOSE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button;
  logic       red, yellow, green;
  logic [7:0] clock;
  logic       pass_request, walk, dont_walk, req_pending, fault, cnt_blank;
  logic [3:0] cnt_tens, cnt_ones;

  int errors = 0;
  int checks = 0;

  ped_crossing_panel #(
    .DEBOUNCE_CYCLES(D), .MIN_WALK(MW), .CLEAR_TIME(CT), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .red(red), .yellow(yellow), .green(green), .clock(clock),
    .pass_request(pass_request), .walk(walk), .dont_walk(dont_walk),
    .req_pending(req_pending), .fault(fault),
    .cnt_tens(cnt_tens), .cnt_ones(cnt_ones), .cnt_blank(cnt_blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  phase;
  int  close_age;
  bit  close_req;
  bit  m_press, m_btn, m_red_prev;
  bit  raw_hist[$];
  bit  e_pass, e_walk, e_dw, e_pend, e_fault, e_blank;
  int  e_tens, e_ones;

  task automatic model_reset();
    phase = P_IDLE; close_age = 0; close_req = 0;
    m_press = 0; m_btn = 0; m_red_prev = 0;
    raw_hist.delete();
    for (int i = 0; i <= D; i++) raw_hist.push_back(1'b0);
    e_pass = 0; e_walk = 0; e_dw = 1; e_pend = 0; e_fault = 0;
    e_blank = 1; e_tens = 0; e_ones = 0;
  endtask

  task automatic model_step();
    int  lit, v, prev_phase;
    bit  bad, accept, show;
    lit = int'(red) + int'(yellow) + int'(green);
    bad = (lit > 1);
    prev_phase = phase;
    if (bad) begin
      phase = P_IDLE; close_req = 0;
    end else if (phase == P_IDLE) begin
      if (m_press) phase = (red && int'(clock) > MW) ? P_CROSS : P_WAIT;
    end else if (phase == P_WAIT) begin
      if (red && !m_red_prev) phase = P_CROSS;
    end else if (phase == P_CROSS) begin
      if (!red) phase = P_IDLE;
      else if (int'(clock) <= CT) phase = P_CLOSE;
    end else begin
      if (m_press) close_req = 1;
      if (!red) begin
        phase = close_req ? P_WAIT : P_IDLE;
        close_req = 0;
      end
    end
    if (phase == P_CLOSE) close_age = (prev_phase == P_CLOSE) ? close_age + 1 : 0;
    m_red_prev = red;

    // Button level seen by the debouncer this edge is the raw value from two
    // edges ago; accept once the last D such samples all disagree.
    accept = 1;
    for (int i = 1; i <= D; i++) if (raw_hist[i] == m_btn) accept = 0;
    m_press = 0;
    if (accept) begin
      m_btn = raw_hist[1];
      m_press = m_btn;
    end
    raw_hist.push_front(button);
    void'(raw_hist.pop_back());

    e_fault = bad;
    e_walk  = (phase == P_CROSS);
    e_pend  = (phase == P_WAIT);
    e_pass  = (phase == P_WAIT) && green;
    if (phase == P_CROSS)      e_dw = 0;
    else if (phase == P_CLOSE) e_dw = ((close_age / FH) % 2) == 0;
    else                       e_dw = 1;
    show    = (phase == P_CROSS) || (phase == P_CLOSE);
    v       = (int'(clock) > 99) ? 99 : int'(clock);
    e_blank = !show;
    e_tens  = show ? v / 10 : 0;
    e_ones  = show ? v % 10 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      if (rst_n) begin
        check("m_pass_request", pass_request, e_pass);
        check("m_walk",         walk,         e_walk);
        check("m_dont_walk",    dont_walk,    e_dw);
        check("m_req_pending",  req_pending,  e_pend);
        check("m_fault",        fault,        e_fault);
        check("m_cnt_tens",     cnt_tens,     e_tens);
        check("m_cnt_ones",     cnt_ones,     e_ones);
        check("m_cnt_blank",    cnt_blank,    e_blank);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 0; button = 1; red = 1; yellow = 0; green = 0; clock = 8'd50;
    step(3);
    check("rst_pass_request", pass_request, 0);
    check("rst_walk",         walk,         0);
    check("rst_dont_walk",    dont_walk,    1);
    check("rst_req_pending",  req_pending,  0);
    check("rst_fault",        fault,        0);
    check("rst_cnt_tens",     cnt_tens,     0);
    check("rst_cnt_ones",     cnt_ones,     0);
    check("rst_cnt_blank",    cnt_blank,    1);

    rst_n = 1; button = 0; red = 0; clock = 8'd0;
    step(4);

    // bounce: 3 high, 1 low, 2 high, low
    green = 1; clock = 8'd40;
    button = 1; step(3);
    button = 0; step(1);
    button = 1; step(2);
    button = 0; step(8);
    check("bounce_pass_request", pass_request, 0);
    check("bounce_req_pending",  req_pending,  0);
    check("bounce_walk",         walk,         0);

    // press during green: request appears exactly 7 edges later
    button = 1;
    step(6);
    check("green_pass_early", pass_request, 0);
    step(1);
    check("green_pass_7",    pass_request, 1);
    check("green_pending_7", req_pending,  1);

    green = 0; yellow = 1; clock = 8'd5; button = 0;
    step(1);
    check("yellow_pass",    pass_request, 0);
    check("yellow_pending", req_pending,  1);

    yellow = 0; red = 1; clock = 8'd10;
    step(1);
    check("redrise_walk",  walk,      1);
    check("redrise_tens",  cnt_tens,  1);
    check("redrise_ones",  cnt_ones,  0);
    check("redrise_blank", cnt_blank, 0);

    // clearance and flash pattern 1,1,0,0,1
    clock = 8'd5; step(1);
    clock = 8'd4; step(1);
    check("walk_at_4", walk, 1);
    clock = 8'd3; step(1);
    check("clear_walk", walk, 0);
    check("flash_0", dont_walk, 1);
    clock = 8'd2; step(1); check("flash_1", dont_walk, 1);
    clock = 8'd1; step(1); check("flash_2", dont_walk, 0);
    clock = 8'd0; step(1); check("flash_3", dont_walk, 0);
    step(1);               check("flash_4", dont_walk, 1);

    red = 0; green = 1; clock = 8'd40;
    step(1);
    check("redfall_dont_walk", dont_walk,    1);
    check("redfall_pass",      pass_request, 0);
    check("redfall_blank",     cnt_blank,    1);

    // press during red with clock > MIN_WALK goes straight to WALK
    green = 0; red = 1; clock = 8'd20;
    button = 1;
    step(6);
    check("direct_walk_early", walk, 0);
    step(1);
    check("direct_walk", walk,     1);
    check("direct_tens", cnt_tens, 2);
    button = 0;
    step(6);
    clock = 8'd3; step(1);
    check("clear2_walk", walk, 0);

    // press during CLEAR is latched until red falls
    clock = 8'd2; button = 1;
    step(8);
    check("clear_press_walk", walk, 0);
    button = 0;
    red = 0; green = 1; clock = 8'd40;
    step(1);
    check("clear_latch_pass",    pass_request, 1);
    check("clear_latch_pending", req_pending,  1);

    // display clamp and fault
    green = 0; red = 1; clock = 8'd60;
    step(1);
    check("disp60_walk", walk,     1);
    check("disp60_tens", cnt_tens, 6);
    check("disp60_ones", cnt_ones, 0);
    clock = 8'd150;
    step(1);
    check("disp150_tens", cnt_tens, 9);
    check("disp150_ones", cnt_ones, 9);
    green = 1;
    step(1);
    check("fault_fault",     fault,       1);
    check("fault_walk",      walk,        0);
    check("fault_dont_walk", dont_walk,   1);
    check("fault_pending",   req_pending, 0);
    green = 0;
    step(1);
    check("postfault_fault", fault, 0);
    check("postfault_walk",  walk,  0);

    // asynchronous reset in the middle of WALK
    step(3);
    button = 1;
    step(7);
    check("prereset_walk", walk, 1);
    #2 rst_n = 0;
    #1;
    check("async_walk",      walk,      0);
    check("async_dont_walk", dont_walk, 1);
    check("async_blank",     cnt_blank, 1);
    check("async_tens",      cnt_tens,  0);
    @(negedge clk);
    rst_n = 1; button = 0; red = 0; clock = 8'd0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
